// File: rtl/rx_frame_store_ctrl.sv
// Stores received frames into a circular byte RAM and commits good frames as
// {start, length} descriptors; bad, oversized or unplaceable frames are rewound.
module rx_frame_store_ctrl #(
  parameter int AW         = 11,
  parameter int MAX_FRAME  = 1522,
  parameter int MIN_FRAME  = 64,
  parameter int STORE_FCS  = 1,
  parameter int CRC_WAIT   = 2,
  parameter int DESC_DEPTH = 4
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic [2:0]    i_state,
  input  logic          i_change,
  input  logic [7:0]    i_data,
  input  logic          i_dv,
  input  logic          i_error,
  input  logic          i_crc_ok,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdata,
  output logic          o_desc_valid,
  output logic [AW-1:0] o_desc_addr,
  output logic [10:0]   o_desc_len,
  input  logic          i_desc_ready,
  input  logic          i_free_valid,
  input  logic [10:0]   i_free_len,
  output logic [AW:0]   o_free,
  output logic [15:0]   o_frames_ok,
  output logic [15:0]   o_frames_drop
);

  localparam int PW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int CW = (CRC_WAIT > 0) ? $clog2(CRC_WAIT + 1) : 1;
  localparam logic [AW:0]     CAP      = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]     FREE_REQ = (AW+1)'(MAX_FRAME);
  localparam logic [10:0]     MAX_LEN  = 11'(MAX_FRAME);
  localparam logic [10:0]     MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [CW-1:0]   CRC_LOAD = CW'(CRC_WAIT);
  localparam logic [PW:0]     DEPTH    = (PW+1)'(DESC_DEPTH);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_CRC, ABORT, DISCARD} state_t;

  function automatic logic byte_accepted(input logic [2:0] st, input logic dv);
    return dv && ((st >= 3'd3 && st <= 3'd6) || (st == 3'd7 && STORE_FCS != 0));
  endfunction

  function automatic logic [AW:0] sat_free(input logic [31:0] v);
    return (v > 32'(CAP)) ? CAP : v[AW:0];
  endfunction

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q, start_q;
  logic [10:0]     len_q;
  logic [CW-1:0]   crc_cnt_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [7:0]      mem_wdata_q;
  logic [AW:0]     free_q, free_d;
  logic [15:0]     ok_q, drop_q;
  logic [PW:0]     wr_idx_q, rd_idx_q;
  logic [AW+10:0]  desc_mem [DESC_DEPTH];

  logic        accept, crc_done, commit, fifo_empty, fifo_full, push, pop;
  logic [PW:0] fifo_cnt;
  logic [31:0] free_sum;

  assign accept     = byte_accepted(i_state, i_dv);
  assign crc_done   = (state_q == WAIT_CRC) && (crc_cnt_q <= CW'(1));
  assign commit     = crc_done && i_crc_ok && (len_q >= MIN_LEN);
  assign fifo_cnt   = wr_idx_q - rd_idx_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH);
  assign push       = commit;
  assign pop        = !fifo_empty && i_desc_ready;

  // Free space: releases and the commit of the current frame net in one step.
  always_comb begin
    free_sum = {{(31-AW){1'b0}}, free_q};
    if (i_free_valid) free_sum = free_sum + {21'b0, i_free_len};
    if (commit)       free_sum = free_sum - {21'b0, len_q};
    free_d = sat_free(free_sum);
  end

  always_ff @(posedge iclk) begin
    if (push) desc_mem[wr_idx_q[PW-1:0]] <= {start_q, len_q};
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      start_q     <= '0;
      len_q       <= '0;
      crc_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      free_q      <= CAP;
      ok_q        <= '0;
      drop_q      <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      free_q   <= free_d;
      if (push) wr_idx_q <= wr_idx_q + 1'b1;
      if (pop)  rd_idx_q <= rd_idx_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (i_change && i_state == 3'd3) begin
            start_q <= wr_ptr_q;
            len_q   <= '0;
            // Admission needs a worst-case frame of space and a descriptor slot.
            if (free_q >= FREE_REQ && !fifo_full) begin
              state_q <= WRITE;
              if (accept) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= wr_ptr_q;
                mem_wdata_q <= i_data;
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                len_q       <= 11'd1;
              end
            end else begin
              state_q <= DISCARD;
              drop_q  <= drop_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (i_error || (accept && len_q == MAX_LEN)) begin
            state_q  <= ABORT;
            wr_ptr_q <= start_q;
            drop_q   <= drop_q + 1'b1;
          end else if (i_change && i_state == 3'd0) begin
            state_q   <= WAIT_CRC;
            crc_cnt_q <= CRC_LOAD;
          end else if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_ptr_q;
            mem_wdata_q <= i_data;
            wr_ptr_q    <= wr_ptr_q + 1'b1;
            len_q       <= len_q + 11'd1;
          end
        end
        WAIT_CRC: begin
          if (crc_done) begin
            state_q <= IDLE;
            if (commit) begin
              ok_q <= ok_q + 1'b1;
            end else begin
              wr_ptr_q <= start_q;
              drop_q   <= drop_q + 1'b1;
            end
          end else begin
            crc_cnt_q <= crc_cnt_q - 1'b1;
          end
        end
        ABORT, DISCARD: begin
          if (i_state == 3'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_desc_valid  = !fifo_empty;
  assign o_desc_addr   = fifo_empty ? '0 : desc_mem[rd_idx_q[PW-1:0]][AW+10:11];
  assign o_desc_len    = fifo_empty ? '0 : desc_mem[rd_idx_q[PW-1:0]][10:0];
  assign o_free        = free_q;
  assign o_frames_ok   = ok_q;
  assign o_frames_drop = drop_q;

endmodule

// File: tb/tb_rx_frame_store_ctrl.sv
// Directed bench for rx_frame_store_ctrl: table of whole-frame vectors plus
// hand-written sequences for abort, wrap, space exhaustion and descriptor FIFO limits.
module tb_rx_frame_store_ctrl;
  localparam int AW = 11;

  logic          iclk = 1'b0;
  logic          irst_n;
  logic [2:0]    i_state;
  logic          i_change, i_dv, i_error, i_crc_ok;
  logic [7:0]    i_data;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_wdata;
  logic          o_desc_valid;
  logic [AW-1:0] o_desc_addr;
  logic [10:0]   o_desc_len;
  logic          i_desc_ready, i_free_valid;
  logic [10:0]   i_free_len;
  logic [AW:0]   o_free;
  logic [15:0]   o_frames_ok, o_frames_drop;

  rx_frame_store_ctrl #(.AW(AW)) dut (
    .iclk(iclk), .irst_n(irst_n), .i_state(i_state), .i_change(i_change),
    .i_data(i_data), .i_dv(i_dv), .i_error(i_error), .i_crc_ok(i_crc_ok),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_desc_valid(o_desc_valid), .o_desc_addr(o_desc_addr), .o_desc_len(o_desc_len),
    .i_desc_ready(i_desc_ready), .i_free_valid(i_free_valid), .i_free_len(i_free_len),
    .o_free(o_free), .o_frames_ok(o_frames_ok), .o_frames_drop(o_frames_drop)
  );

  always #5 iclk = ~iclk;

  int n_chk = 0, n_err = 0;
  int tot_we = 0, tot_bad = 0;
  int mon_base = 0, mon_snap = 0, bad_snap = 0;

  function automatic logic [7:0] byte_of(input int k);
    return 8'((k * 37 + 5) & 255);
  endfunction

  function automatic logic [2:0] state_of(input int k, input int n);
    if (k < 6)       return 3'd3;
    if (k < 12)      return 3'd4;
    if (k < 14)      return 3'd5;
    if (k >= n - 4)  return 3'd7;
    return 3'd6;
  endfunction

  // Every write must land at base+k (mod RAM size) carrying frame byte k.
  always @(negedge iclk) begin
    int k;
    if (o_mem_we) begin
      k = tot_we - mon_snap;
      if (o_mem_addr !== 11'((mon_base + k) % 2048) || o_mem_wdata !== byte_of(k))
        tot_bad++;
      tot_we++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic begin_mon(input int base);
    mon_base = base;
    mon_snap = tot_we;
    bad_snap = tot_bad;
  endtask

  task automatic check_mon(input string nm, input int exp_w);
    chk({nm, "_writes"}, tot_we - mon_snap, exp_w);
    chk({nm, "_wrbad"}, tot_bad - bad_snap, 0);
  endtask

  task automatic drive_frame(input int n, input bit crc, input int err_at);
    logic [2:0] st, prev;
    prev = 3'd0;
    i_crc_ok = crc;
    for (int k = 0; k < n; k++) begin
      st       = state_of(k, n);
      i_state  = st;
      i_change = (st != prev);
      i_dv     = 1'b1;
      i_data   = byte_of(k);
      i_error  = (k == err_at);
      prev     = st;
      @(posedge iclk); #1;
    end
  endtask

  // Frame end; an optional release is lined up with the commit cycle.
  task automatic end_frame(input int fl);
    i_state = 3'd0; i_change = 1'b1; i_dv = 1'b0; i_error = 1'b0;
    @(posedge iclk); #1;
    i_change = 1'b0;
    @(posedge iclk); #1;
    if (fl > 0) begin
      i_free_valid = 1'b1;
      i_free_len   = 11'(fl);
    end
    @(posedge iclk); #1;
    i_free_valid = 1'b0;
    i_free_len   = '0;
    repeat (4) @(posedge iclk);
    #1;
  endtask

  task automatic run_frame(input string nm, input int n, input bit crc, input int base, input int exp_w);
    begin_mon(base);
    drive_frame(n, crc, -1);
    end_frame(0);
    check_mon(nm, exp_w);
  endtask

  task automatic free_bytes(input int len);
    i_free_valid = 1'b1;
    i_free_len   = 11'(len);
    @(posedge iclk); #1;
    i_free_valid = 1'b0;
    i_free_len   = '0;
  endtask

  task automatic pop_desc(input string nm, input int addr, input int len);
    chk({nm, "_dvalid"}, int'(o_desc_valid), 1);
    chk({nm, "_daddr"}, int'(o_desc_addr), addr);
    chk({nm, "_dlen"}, int'(o_desc_len), len);
    i_desc_ready = 1'b1;
    @(posedge iclk); #1;
    i_desc_ready = 1'b0;
  endtask

  typedef struct {
    int n; bit crc; int base; int exp_w; bit desc; int ok; int drop; int free;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{n: 78,  crc: 1'b1, base: 0,   exp_w: 78,  desc: 1'b1, ok: 1, drop: 0, free: 1970};
    tbl[1] = '{n: 78,  crc: 1'b0, base: 78,  exp_w: 78,  desc: 1'b0, ok: 1, drop: 1, free: 1970};
    tbl[2] = '{n: 64,  crc: 1'b1, base: 78,  exp_w: 64,  desc: 1'b1, ok: 2, drop: 1, free: 1906};
    tbl[3] = '{n: 63,  crc: 1'b1, base: 142, exp_w: 63,  desc: 1'b0, ok: 2, drop: 2, free: 1906};
    tbl[4] = '{n: 100, crc: 1'b1, base: 142, exp_w: 100, desc: 1'b1, ok: 3, drop: 2, free: 1806};

    irst_n = 1'b0; i_state = '0; i_change = 0; i_data = '0; i_dv = 0; i_error = 0;
    i_crc_ok = 0; i_desc_ready = 0; i_free_valid = 0; i_free_len = '0;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_we", int'(o_mem_we), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_wdata", int'(o_mem_wdata), 0);
    chk("rst_dvalid", int'(o_desc_valid), 0);
    chk("rst_daddr", int'(o_desc_addr), 0);
    chk("rst_dlen", int'(o_desc_len), 0);
    chk("rst_free", int'(o_free), 2048);
    chk("rst_ok", int'(o_frames_ok), 0);
    chk("rst_drop", int'(o_frames_drop), 0);
    irst_n = 1'b1;
    repeat (2) @(posedge iclk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].n, tbl[i].crc, tbl[i].base, tbl[i].exp_w);
      if (tbl[i].desc) pop_desc($sformatf("tbl%0d", i), tbl[i].base, tbl[i].n);
      else chk($sformatf("tbl%0d_nodesc", i), int'(o_desc_valid), 0);
      chk($sformatf("tbl%0d_ok", i), int'(o_frames_ok), tbl[i].ok);
      chk($sformatf("tbl%0d_drop", i), int'(o_frames_drop), tbl[i].drop);
      chk($sformatf("tbl%0d_free", i), int'(o_free), tbl[i].free);
    end

    // Error at the 20th data byte; a restart seen before i_state=0 must be ignored.
    begin_mon(242);
    drive_frame(78, 1'b1, 33);
    drive_frame(20, 1'b1, -1);
    end_frame(0);
    check_mon("err", 33);
    chk("err_nodesc", int'(o_desc_valid), 0);
    chk("err_drop", int'(o_frames_drop), 3);
    chk("err_ok", int'(o_frames_ok), 3);
    run_frame("after_err", 78, 1'b1, 242, 78);
    pop_desc("after_err", 242, 78);
    chk("after_err_free", int'(o_free), 1728);

    // Advance the write pointer to 2000, then store a frame across the wrap.
    for (int i = 0; i < 7; i++) begin
      run_frame("adv", 240, 1'b1, 320 + 240 * i, 240);
      pop_desc("adv", 320 + 240 * i, 240);
      free_bytes(240);
    end
    chk("adv_free", int'(o_free), 1728);
    run_frame("wrap", 100, 1'b1, 2000, 100);
    pop_desc("wrap", 2000, 100);
    chk("wrap_free", int'(o_free), 1628);
    chk("wrap_ok", int'(o_frames_ok), 12);

    // Space below one maximum frame: discard, release, resume.
    run_frame("low", 200, 1'b1, 52, 200);
    pop_desc("low", 52, 200);
    chk("low_free", int'(o_free), 1428);
    run_frame("nospace", 78, 1'b1, 252, 0);
    chk("nospace_nodesc", int'(o_desc_valid), 0);
    chk("nospace_drop", int'(o_frames_drop), 4);
    chk("nospace_ok", int'(o_frames_ok), 13);
    free_bytes(1522);
    chk("free_sat", int'(o_free), 2048);
    run_frame("resume", 78, 1'b1, 252, 78);
    pop_desc("resume", 252, 78);
    chk("resume_free", int'(o_free), 1970);

    // Commit and release in the same cycle.
    run_frame("big", 370, 1'b1, 330, 370);
    pop_desc("big", 330, 370);
    chk("big_free", int'(o_free), 1600);
    begin_mon(700);
    drive_frame(78, 1'b1, -1);
    end_frame(300);
    check_mon("cfree", 78);
    pop_desc("cfree", 700, 78);
    chk("cfree_free", int'(o_free), 1822);
    chk("cfree_ok", int'(o_frames_ok), 16);

    // Descriptor FIFO full: the fifth frame is discarded.
    for (int i = 0; i < 4; i++) run_frame("fifo", 64, 1'b1, 778 + 64 * i, 64);
    chk("fifo_free", int'(o_free), 1566);
    run_frame("fifo_full", 64, 1'b1, 1034, 0);
    chk("fifo_full_drop", int'(o_frames_drop), 5);
    chk("fifo_full_ok", int'(o_frames_ok), 20);
    for (int i = 0; i < 4; i++) pop_desc("fifo_pop", 778 + 64 * i, 64);
    chk("fifo_empty", int'(o_desc_valid), 0);

    // Reset in the middle of a frame.
    begin_mon(1034);
    drive_frame(12, 1'b1, -1);
    irst_n = 1'b0;
    #1;
    chk("mrst_we", int'(o_mem_we), 0);
    chk("mrst_free", int'(o_free), 2048);
    chk("mrst_ok", int'(o_frames_ok), 0);
    chk("mrst_drop", int'(o_frames_drop), 0);
    chk("mrst_dvalid", int'(o_desc_valid), 0);
    @(posedge iclk); #1;
    irst_n = 1'b1;
    end_frame(0);
    chk("mrst_drop_after", int'(o_frames_drop), 0);
    run_frame("post_rst", 64, 1'b1, 0, 64);
    pop_desc("post_rst", 0, 64);
    chk("post_rst_ok", int'(o_frames_ok), 1);
    chk("post_rst_free", int'(o_free), 1984);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
